// File: rtl/sdio_data_xfer_ctrl.sv
// SDIO block-transfer sequencer: arms the data PHY once per block and moves
// payload through one shared byte FIFO, reporting per-transfer completion status.
module sdio_data_xfer_ctrl #(
  parameter int FIFO_AW        = 9,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_xfer_start,
  input  logic       i_xfer_write,
  input  logic [9:0] i_block_size,
  input  logic [8:0] i_block_count,
  input  logic       i_xfer_abort,
  output logic       o_xfer_busy,
  output logic       o_xfer_done,
  output logic [1:0] o_xfer_status,
  output logic [8:0] o_blocks_done,
  input  logic       i_fn_stb,
  input  logic [7:0] i_fn_data,
  output logic       o_fn_rdy,
  output logic       o_fn_stb,
  output logic [7:0] o_fn_data,
  input  logic       i_fn_rdy,
  output logic       o_phy_activate,
  output logic       o_phy_write_flag,
  output logic [9:0] o_phy_data_count,
  input  logic       i_phy_wr_stb,
  input  logic [7:0] i_phy_wr_data,
  input  logic       i_phy_rd_req,
  output logic       o_phy_rd_stb,
  output logic [7:0] o_phy_rd_data,
  output logic       o_phy_com_rdy,
  input  logic       i_phy_finished,
  input  logic       i_phy_crc_good
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_CRC  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_CRC   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  logic [2:0]  state_q, state_d;
  logic        wr_q;
  logic [9:0]  size_q;
  logic [8:0]  count_q;
  logic [8:0]  blocks_q, blocks_d;
  logic [9:0]  bcnt_q, bcnt_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  gap_q, gap_d;
  logic        act_q, act_d;
  logic        com_q, com_d;
  logic        done_q, done_d;
  logic [1:0]  status_q, status_d;
  logic        rd_stb_q;
  logic [7:0]  rd_data_q;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]   cnt_q;

  logic        busy, full, empty;
  logic        phy_push, phy_pop, fn_push, fn_pop, push, pop;
  logic [7:0]  push_data;
  logic        byte_evt, abort, start_ok, inv_start, flush, arm_ok;
  logic [15:0] cnt_w, size_w;
  logic [16:0] timer_inc;
  logic        timeout_hit;

  assign busy  = (state_q != S_IDLE);
  assign full  = cnt_q[FIFO_AW];
  assign empty = (cnt_q == '0);

  // Write mode: PHY fills, function drains. Read mode: function fills, PHY drains.
  assign o_fn_rdy  = busy && !wr_q && !full;
  assign o_fn_stb  = wr_q && !empty;
  assign o_fn_data = o_fn_stb ? mem_q[rp_q] : 8'h00;

  assign phy_push  = wr_q && (state_q == S_XFER) && i_phy_wr_stb && !full;
  assign phy_pop   = !wr_q && (state_q == S_XFER) && i_phy_rd_req && !empty;
  assign fn_push   = i_fn_stb && o_fn_rdy;
  assign fn_pop    = o_fn_stb && i_fn_rdy;
  assign push      = phy_push || fn_push;
  assign pop       = phy_pop || fn_pop;
  assign push_data = wr_q ? i_phy_wr_data : i_fn_data;
  assign byte_evt  = phy_push || phy_pop;

  assign cnt_w  = 16'(cnt_q);
  assign size_w = {6'd0, size_q};
  assign arm_ok = wr_q ? ((16'(DEPTH) - cnt_w) >= size_w) : (cnt_w >= size_w);

  assign timer_inc   = {1'b0, timer_q} + 17'd1;
  assign timeout_hit = (timer_inc == 17'(TIMEOUT_CYCLES));

  // DONE is already on its way out, so a late abort there has nothing to stop.
  assign abort = i_xfer_abort && busy && (state_q != S_DONE);
  assign flush = start_ok || abort;

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    com_d     = com_q;
    status_d  = status_q;
    blocks_d  = blocks_q;
    bcnt_d    = bcnt_q;
    gap_d     = gap_q;
    timer_d   = '0;
    start_ok  = 1'b0;
    inv_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_xfer_start) begin
          if (i_block_size == 10'd0) begin
            inv_start = 1'b1;
            status_d  = ST_TMO;
          end else begin
            start_ok = 1'b1;
            status_d = ST_OK;
            blocks_d = '0;
            bcnt_d   = '0;
            state_d  = S_ARM;
          end
        end
      end
      S_ARM: begin
        bcnt_d = '0;
        if (arm_ok) begin
          act_d   = 1'b1;
          com_d   = !wr_q;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (byte_evt) begin
          bcnt_d = bcnt_q + 10'd1;
          if (bcnt_q + 10'd1 == size_q) state_d = S_CRC;
        end else if (timeout_hit) begin
          act_d    = 1'b0;
          com_d    = 1'b0;
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_inc[15:0];
        end
      end
      S_CRC: begin
        if (i_phy_finished) begin
          act_d = 1'b0;
          com_d = 1'b0;
          if (wr_q && !i_phy_crc_good) begin
            status_d = ST_CRC;
            state_d  = S_DONE;
          end else begin
            if (blocks_q != 9'h1FF) blocks_d = blocks_q + 9'd1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (timeout_hit) begin
          act_d    = 1'b0;
          com_d    = 1'b0;
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_inc[15:0];
        end
      end
      S_GAP: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          if ((count_q != 9'd0) && (blocks_q == count_q)) begin
            status_d = ST_OK;
            state_d  = S_DONE;
          end else begin
            state_d = S_ARM;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      act_d    = 1'b0;
      com_d    = 1'b0;
      status_d = ST_ABORT;
      state_d  = S_DONE;
    end
  end

  // DONE lasts exactly one cycle, so registering its entry gives the pulse.
  assign done_d = (state_d == S_DONE) || inv_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      size_q    <= '0;
      count_q   <= '0;
      blocks_q  <= '0;
      bcnt_q    <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      act_q     <= 1'b0;
      com_q     <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      rd_stb_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      blocks_q <= blocks_d;
      bcnt_q   <= bcnt_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      act_q    <= act_d;
      com_q    <= com_d;
      done_q   <= done_d;
      status_q <= status_d;
      rd_stb_q <= phy_pop;
      if (phy_pop) rd_data_q <= mem_q[rp_q];
      if (start_ok) begin
        wr_q    <= i_xfer_write;
        size_q  <= i_block_size;
        count_q <= i_block_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= push_data;
  end

  assign o_xfer_busy      = busy;
  assign o_xfer_done      = done_q;
  assign o_xfer_status    = status_q;
  assign o_blocks_done    = blocks_q;
  assign o_phy_activate   = act_q;
  assign o_phy_write_flag = wr_q;
  assign o_phy_data_count = size_q;
  assign o_phy_rd_stb     = rd_stb_q;
  assign o_phy_rd_data    = rd_data_q;
  assign o_phy_com_rdy    = com_q;

endmodule
